// File: rtl/sig_acq_pkg.sv
// sig_acq_pkg
//   Shared definitions for the acquisition readout block: default data and
//   address widths and the readout FSM state encoding.
package sig_acq_pkg;

   localparam int SIG_DW_DEFAULT = 16;
   localparam int SIG_AW_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_DONE = 3'd4
   } rd_state_t;

endpackage

// File: rtl/sig_readout.sv
// sig_readout
//   Streams samples stripnum..acqnum-1 out of the acquisition RAM to a
//   host/DSP through a valid/ready output register, accumulating a 16-bit
//   running checksum of every transferred sample.
//
// Ports
//   clk_sys      system clock, all logic on the rising edge
//   s_reset      synchronous active-high reset
//   rd_start     one-cycle readout request (ignored while rd_busy)
//   rd_abort     cancels a readout in progress
//   acqnum       total samples held in the RAM (latched on start)
//   stripnum     leading samples to discard (latched on start)
//   ram_rd       RAM read strobe
//   ram_addr     RAM read address
//   ram_data     RAM read data, valid one cycle after ram_rd
//   dout         sample to the host
//   dout_valid   dout holds a valid sample
//   dout_ready   host accepts the sample
//   rd_busy      readout in progress
//   rd_done      one-cycle pulse on normal completion
//   checksum     modulo-2^16 sum of the transferred samples
module sig_readout
   import sig_acq_pkg::*;
#(
   parameter int DW = SIG_DW_DEFAULT,
   parameter int AW = SIG_AW_DEFAULT
) (
   input  logic          clk_sys,
   input  logic          s_reset,
   input  logic          rd_start,
   input  logic          rd_abort,
   input  logic [15:0]   acqnum,
   input  logic [11:0]   stripnum,
   output logic          ram_rd,
   output logic [AW-1:0] ram_addr,
   input  logic [DW-1:0] ram_data,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic          rd_busy,
   output logic          rd_done,
   output logic [15:0]   checksum
);

   rd_state_t       state_q, state_d;
   logic [15:0]     addr_q, addr_d;
   logic [15:0]     acq_q, acq_d;
   logic [15:0]     checksum_q, checksum_d;
   logic            ram_rd_q, ram_rd_d;
   logic [AW-1:0]   ram_addr_q, ram_addr_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic            dout_valid_q, dout_valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [15:0]     strip_ext;
   logic [16:0]     addr_inc;
   logic [15:0]     sample16;

   assign strip_ext = {4'b0000, stripnum};
   // One extra bit so the end-of-block compare can never wrap.
   assign addr_inc  = {1'b0, addr_q} + 17'd1;
   assign sample16  = 16'(ram_data);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      acq_d        = acq_q;
      checksum_d   = checksum_q;
      ram_rd_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      if (state_q != ST_IDLE && rd_abort) begin
         // Abort wins over the handshake and over completion: no rd_done,
         // checksum keeps whatever has been summed so far.
         state_d      = ST_IDLE;
         dout_valid_d = 1'b0;
         busy_d       = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // rd_busy trails DONE by one cycle; clearing it here ends a
               // readout and also keeps rd_start ignored during that cycle.
               busy_d = 1'b0;
               if (rd_start && !busy_q) begin
                  acq_d      = acqnum;
                  addr_d     = strip_ext;
                  checksum_d = '0;
                  busy_d     = 1'b1;
                  if (strip_ext >= acqnum) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d    = ST_RD;
                     ram_rd_d   = 1'b1;
                     ram_addr_d = AW'(strip_ext);
                  end
               end
            end
            ST_RD: begin
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               dout_d       = ram_data;
               checksum_d   = checksum_q + sample16;
               dout_valid_d = 1'b1;
               state_d      = ST_HOLD;
            end
            ST_HOLD: begin
               if (dout_ready) begin
                  dout_valid_d = 1'b0;
                  addr_d       = addr_inc[15:0];
                  if (addr_inc < {1'b0, acq_q}) begin
                     state_d    = ST_RD;
                     ram_rd_d   = 1'b1;
                     ram_addr_d = AW'(addr_inc[15:0]);
                  end else begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d      = ST_IDLE;
               dout_valid_d = 1'b0;
               busy_d       = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (s_reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         acq_q        <= '0;
         checksum_q   <= '0;
         ram_rd_q     <= 1'b0;
         ram_addr_q   <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         acq_q        <= acq_d;
         checksum_q   <= checksum_d;
         ram_rd_q     <= ram_rd_d;
         ram_addr_q   <= ram_addr_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign ram_rd     = ram_rd_q;
   assign ram_addr   = ram_addr_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign rd_busy    = busy_q;
   assign rd_done    = done_q;
   assign checksum   = checksum_q;

endmodule

// File: tb/tb_sig_readout.sv
// tb_sig_readout
//   Directed bench for sig_readout: a behavioural RAM holding 0x100+addr,
//   a negedge monitor logging reads and handshakes, and hand-computed
//   expectations for each readout scenario.
module tb_sig_readout;

   logic        clk_sys = 1'b0;
   logic        s_reset;
   logic        rd_start;
   logic        rd_abort;
   logic [15:0] acqnum;
   logic [11:0] stripnum;
   logic        ram_rd;
   logic [15:0] ram_addr;
   logic [15:0] ram_data = '0;
   logic [15:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        rd_busy;
   logic        rd_done;
   logic [15:0] checksum;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   logic [15:0] rd_addrs[$];
   logic [15:0] samples[$];
   int valid_cnt, busy_cnt, done_cnt;
   int first_valid, last_hs, done_cyc;

   sig_readout #(.DW(16), .AW(16)) dut (
      .clk_sys    (clk_sys),
      .s_reset    (s_reset),
      .rd_start   (rd_start),
      .rd_abort   (rd_abort),
      .acqnum     (acqnum),
      .stripnum   (stripnum),
      .ram_rd     (ram_rd),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .rd_busy    (rd_busy),
      .rd_done    (rd_done),
      .checksum   (checksum)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   // RAM content: word at address a is 0x100 + a, one-cycle read latency.
   always @(posedge clk_sys) begin
      if (ram_rd) ram_data <= 16'h0100 + ram_addr;
   end

   always @(negedge clk_sys) begin
      if (ram_rd) rd_addrs.push_back(ram_addr);
      if (dout_valid) begin
         valid_cnt++;
         if (first_valid < 0) first_valid = cyc;
         if (dout_ready) begin
            samples.push_back(dout);
            last_hs = cyc;
         end
      end
      if (rd_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (rd_busy) busy_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic clear_mon();
      rd_addrs.delete();
      samples.delete();
      valid_cnt   = 0;
      busy_cnt    = 0;
      done_cnt    = 0;
      first_valid = -1;
      last_hs     = -1;
      done_cyc    = -1;
   endtask

   task automatic start_rd(input logic [15:0] acq, input logic [11:0] strip, output int c0);
      clear_mon();
      acqnum   = acq;
      stripnum = strip;
      rd_start = 1'b1;
      c0       = cyc;
      step();
      rd_start = 1'b0;
   endtask

   // Waits for rd_done; with noise set, keeps toggling rd_start and scrambling
   // acqnum/stripnum while the readout runs.
   task automatic wait_done(input int budget, input bit noise);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (rd_done) begin
            seen = 1'b1;
         end else begin
            if (noise) begin
               rd_start = ~rd_start;
               acqnum   = acqnum + 16'd3;
               stripnum = stripnum ^ 12'h005;
            end
            step();
         end
      end
      rd_start = 1'b0;
      check("done_seen", {31'd0, seen}, 32'd1);
      repeat (3) step();
   endtask

   task automatic check_readout(input int acq, input int strip);
      int n;
      logic [15:0] sum;
      logic [15:0] e;
      n   = (strip < acq) ? acq - strip : 0;
      sum = '0;
      check("n_samples", samples.size(), n);
      check("n_reads", rd_addrs.size(), n);
      for (int i = 0; i < n; i++) begin
         e   = 16'(32'h100 + strip + i);
         sum = sum + e;
         if (i < samples.size())  check("sample", {16'd0, samples[i]}, {16'd0, e});
         if (i < rd_addrs.size()) check("addr", {16'd0, rd_addrs[i]}, 32'(strip + i));
      end
      check("checksum", {16'd0, checksum}, {16'd0, sum});
      check("done_pulses", done_cnt, 1);
      check("busy_after", {31'd0, rd_busy}, 32'd0);
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_ram_rd"},     {31'd0, ram_rd},     32'd0);
      check({pfx, "_ram_addr"},   {16'd0, ram_addr},   32'd0);
      check({pfx, "_dout"},       {16'd0, dout},       32'd0);
      check({pfx, "_dout_valid"}, {31'd0, dout_valid}, 32'd0);
      check({pfx, "_rd_busy"},    {31'd0, rd_busy},    32'd0);
      check({pfx, "_rd_done"},    {31'd0, rd_done},    32'd0);
      check({pfx, "_checksum"},   {16'd0, checksum},   32'd0);
   endtask

   initial begin
      int c0;
      bit found;
      s_reset    = 1'b1;
      rd_start   = 1'b0;
      rd_abort   = 1'b0;
      acqnum     = '0;
      stripnum   = '0;
      dout_ready = 1'b1;
      clear_mon();
      repeat (3) step();
      check_reset_vals("rst");
      s_reset = 1'b0;
      step();

      // Basic readout: 8 samples, strip 2 -> 0x102..0x107, sum 0x061B.
      start_rd(16'd8, 12'd2, c0);
      wait_done(100, 1'b0);
      check_readout(8, 2);
      check("first_latency", first_valid - c0, 3);
      check("last_hs_cycle", last_hs - c0, 18);
      check("done_after_hs", done_cyc - last_hs, 1);

      // Empty readouts: strip == acq, and acq == 0.
      start_rd(16'd5, 12'd5, c0);
      wait_done(20, 1'b0);
      check_readout(5, 5);
      check("empty_valid", valid_cnt, 0);
      check("empty_busy_cycles", busy_cnt, 2);
      start_rd(16'd0, 12'd0, c0);
      wait_done(20, 1'b0);
      check_readout(0, 0);
      check("zero_valid", valid_cnt, 0);
      check("zero_busy_cycles", busy_cnt, 2);

      // Host stall on the first sample for 10 cycles.
      dout_ready = 1'b0;
      start_rd(16'd4, 12'd0, c0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (dout_valid) found = 1'b1;
         else step();
      end
      check("stall_valid_seen", {31'd0, found}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         check("stall_valid", {31'd0, dout_valid}, 32'd1);
         check("stall_dout", {16'd0, dout}, 32'h0100);
      end
      check("stall_no_rd", rd_addrs.size(), 1);
      dout_ready = 1'b1;
      wait_done(100, 1'b0);
      check_readout(4, 0);

      // Abort in HOLD on sample 3 of 8, with dout_ready also high.
      start_rd(16'd8, 12'd0, c0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (dout_valid && dout == 16'h0103) found = 1'b1;
         else step();
      end
      check("abort_hold_seen", {31'd0, found}, 32'd1);
      rd_abort = 1'b1;
      step();
      rd_abort = 1'b0;
      check("abort_valid", {31'd0, dout_valid}, 32'd0);
      check("abort_ram_rd", {31'd0, ram_rd}, 32'd0);
      check("abort_busy", {31'd0, rd_busy}, 32'd0);
      check("abort_done", {31'd0, rd_done}, 32'd0);
      check("abort_checksum", {16'd0, checksum}, 32'h0406);
      repeat (4) step();
      check("abort_no_done", done_cnt, 0);
      check("abort_idle_reads", rd_addrs.size(), 4);
      start_rd(16'd3, 12'd1, c0);
      wait_done(100, 1'b0);
      check_readout(3, 1);

      // rd_start and acqnum/stripnum churn during a readout.
      start_rd(16'd6, 12'd1, c0);
      wait_done(100, 1'b1);
      check_readout(6, 1);

      // Reset while in WAIT, then restart on the first cycle after reset.
      start_rd(16'd6, 12'd2, c0);
      step();
      s_reset = 1'b1;
      step();
      check_reset_vals("midrst");
      s_reset = 1'b0;
      start_rd(16'd3, 12'd0, c0);
      wait_done(100, 1'b0);
      check_readout(3, 0);
      check("rst_restart_latency", first_valid - c0, 3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
